// File: rtl/controlador_calculadora.sv
// Calculator entry/compute controller: accumulates two decimal operands, latches the operation, evaluates on equals.
// Optional backspace on key 1111 is built only when APAGAR_EN is defined.
module controlador_calculadora #(
    parameter int unsigned NUM_DIGITOS = 4,
    parameter int unsigned LARGURA     = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         dado,
    input  logic               dado_valido,
    input  logic [1:0]         op_codificada,
    input  logic               eh_igual,
    output logic [LARGURA-1:0] valor_display,
    output logic               negativo,
    output logic               erro,
    output logic               pronto
);
    localparam int unsigned MAX    = 10**NUM_DIGITOS - 1;
    localparam int unsigned CW     = $clog2(NUM_DIGITOS + 1);
    localparam int unsigned CALC_W = 2 * LARGURA;

    localparam logic [1:0] OP_ADD  = 2'b11;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [3:0] K_CLEAR = 4'b1110;
`ifdef APAGAR_EN
    localparam logic [3:0] K_APAGA = 4'b1111;
`endif

    typedef enum logic [2:0] {S_A, S_B, S_CALC, S_RES, S_ERRO} estado_t;

    estado_t            state_q, state_d;
    logic [LARGURA-1:0] a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
    logic [CW-1:0]      cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d, erro_q, erro_d, pronto_q, pronto_d;

    logic               eh_digito, eh_op;
    logic [LARGURA-1:0] digito;
    logic [CALC_W-1:0]  a_ext, b_ext, calc_mag;
    logic               calc_neg, calc_ovf;

    assign eh_digito = (dado <= 4'd9);
    assign eh_op     = (op_codificada != OP_NONE);
    assign digito    = LARGURA'(dado);

    // Evaluation datapath, wide enough that the product never wraps before the range check.
    always_comb begin
        a_ext    = CALC_W'(a_q);
        b_ext    = CALC_W'(b_q);
        calc_mag = a_ext;
        calc_neg = 1'b0;
        case (op_q)
            OP_ADD: calc_mag = a_ext + b_ext;
            OP_SUB: begin
                calc_neg = (a_q < b_q);
                calc_mag = calc_neg ? (b_ext - a_ext) : (a_ext - b_ext);
            end
            OP_MUL: calc_mag = a_ext * b_ext;
            default: calc_mag = a_ext;
        endcase
        calc_ovf = (calc_mag > CALC_W'(MAX));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        disp_d   = disp_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        op_d     = op_q;
        neg_d    = neg_q;
        erro_d   = erro_q;
        pronto_d = 1'b0;

        if (state_q == S_CALC) begin
            if (calc_ovf) begin
                erro_d  = 1'b1;
                disp_d  = '0;
                state_d = S_ERRO;
            end else begin
                res_d    = LARGURA'(calc_mag);
                disp_d   = LARGURA'(calc_mag);
                neg_d    = calc_neg;
                pronto_d = 1'b1;
                state_d  = S_RES;
            end
        end else if (dado_valido) begin
            if (dado == K_CLEAR) begin
                state_d = S_A;
                a_d     = '0;
                b_d     = '0;
                res_d   = '0;
                disp_d  = '0;
                cnt_a_d = '0;
                cnt_b_d = '0;
                op_d    = OP_NONE;
                neg_d   = 1'b0;
                erro_d  = 1'b0;
            end else begin
                case (state_q)
                    S_A: begin
                        if (eh_digito) begin
                            // A leading zero keeps the operand at zero without spending a digit slot.
                            if (!(a_q == '0 && dado == 4'd0) && cnt_a_q < CW'(NUM_DIGITOS)) begin
                                a_d     = a_q * LARGURA'(10) + digito;
                                cnt_a_d = cnt_a_q + CW'(1);
                                disp_d  = a_q * LARGURA'(10) + digito;
                            end
                        end else if (eh_op) begin
                            op_d    = op_codificada;
                            b_d     = '0;
                            cnt_b_d = '0;
                            disp_d  = '0;
                            state_d = S_B;
                        end else if (eh_igual) begin
                            op_d    = OP_NONE;
                            state_d = S_CALC;
                        end
`ifdef APAGAR_EN
                        else if (dado == K_APAGA && cnt_a_q != '0) begin
                            a_d     = a_q / LARGURA'(10);
                            cnt_a_d = cnt_a_q - CW'(1);
                            disp_d  = a_q / LARGURA'(10);
                        end
`endif
                    end
                    S_B: begin
                        if (eh_digito) begin
                            if (!(b_q == '0 && dado == 4'd0) && cnt_b_q < CW'(NUM_DIGITOS)) begin
                                b_d     = b_q * LARGURA'(10) + digito;
                                cnt_b_d = cnt_b_q + CW'(1);
                                disp_d  = b_q * LARGURA'(10) + digito;
                            end
                        end else if (eh_op) begin
                            if (cnt_b_q == '0) op_d = op_codificada;
                        end else if (eh_igual) begin
                            state_d = S_CALC;
                        end
`ifdef APAGAR_EN
                        else if (dado == K_APAGA && cnt_b_q != '0) begin
                            b_d     = b_q / LARGURA'(10);
                            cnt_b_d = cnt_b_q - CW'(1);
                            disp_d  = b_q / LARGURA'(10);
                        end
`endif
                    end
                    S_RES: begin
                        if (eh_digito) begin
                            a_d     = digito;
                            cnt_a_d = CW'(1);
                            neg_d   = 1'b0;
                            disp_d  = digito;
                            state_d = S_A;
                        end else if (eh_op && !neg_q) begin
                            // Chaining: the held result becomes the first operand.
                            a_d     = res_q;
                            op_d    = op_codificada;
                            b_d     = '0;
                            cnt_b_d = '0;
                            disp_d  = '0;
                            state_d = S_B;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            disp_q   <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            op_q     <= OP_NONE;
            neg_q    <= 1'b0;
            erro_q   <= 1'b0;
            pronto_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            disp_q   <= disp_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            erro_q   <= erro_d;
            pronto_q <= pronto_d;
        end
    end

    assign valor_display = disp_q;
    assign negativo      = neg_q;
    assign erro          = erro_q;
    assign pronto        = pronto_q;

endmodule

// File: tb/tb_controlador_calculadora.sv
// Bench for controlador_calculadora: directed test-plan sequences plus random keys against a behavioural model.
module tb_controlador_calculadora;
    localparam int unsigned LARGURA = 14;
    localparam int ND   = 4;
    localparam int MAXV = 9999;

    localparam int M_A = 0, M_B = 1, M_CALC = 2, M_RES = 3, M_ERR = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         dado;
    logic               dado_valido;
    logic [1:0]         op_codificada;
    logic               eh_igual;
    logic [LARGURA-1:0] valor_display;
    logic               negativo;
    logic               erro;
    logic               pronto;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: operands as plain integers, op remembered as its key code (0 = identity).
    int m_mode, m_a, m_b, m_na, m_nb, m_op, m_res, m_disp;
    bit m_neg, m_err, m_pronto;

    controlador_calculadora #(.NUM_DIGITOS(4), .LARGURA(14)) dut (
        .clk(clk), .rst(rst), .dado(dado), .dado_valido(dado_valido),
        .op_codificada(op_codificada), .eh_igual(eh_igual),
        .valor_display(valor_display), .negativo(negativo), .erro(erro), .pronto(pronto)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input int k);
        case (k)
            10: return 2'b11;
            11: return 2'b10;
            12: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_A; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_res = 0;
        m_disp = 0; m_neg = 0; m_err = 0; m_pronto = 0;
    endtask

    task automatic entry_key(inout int val, inout int n, input int k);
        if (k <= 9) begin
            if ((val != 0 || k != 0) && n < ND) begin
                val = val * 10 + k;
                n++;
            end
        end
`ifdef APAGAR_EN
        else if (k == 15 && n > 0) begin
            val = val / 10;
            n--;
        end
`endif
    endtask

    task automatic model_edge(input bit r, input bit v, input int k);
        int full, mag;
        m_pronto = 0;
        if (r) begin model_reset(); return; end
        if (m_mode == M_CALC) begin
            case (m_op)
                10: full = m_a + m_b;
                11: full = m_a - m_b;
                12: full = m_a * m_b;
                default: full = m_a;
            endcase
            mag = (full < 0) ? -full : full;
            if (mag > MAXV) begin
                m_err = 1; m_disp = 0; m_mode = M_ERR;
            end else begin
                m_res = mag; m_disp = mag; m_neg = (full < 0); m_pronto = 1; m_mode = M_RES;
            end
            return;
        end
        if (!v) return;
        if (k == 14) begin model_reset(); return; end
        if (m_mode == M_A) begin
            if (k >= 10 && k <= 12) begin
                m_op = k; m_b = 0; m_nb = 0; m_disp = 0; m_mode = M_B;
            end else if (k == 13) begin
                m_op = 0; m_mode = M_CALC;
            end else begin
                entry_key(m_a, m_na, k);
                m_disp = m_a;
            end
        end else if (m_mode == M_B) begin
            if (k >= 10 && k <= 12) begin
                if (m_nb == 0) m_op = k;
            end else if (k == 13) begin
                m_mode = M_CALC;
            end else begin
                entry_key(m_b, m_nb, k);
                m_disp = m_b;
            end
        end else if (m_mode == M_RES) begin
            if (k <= 9) begin
                m_a = k; m_na = 1; m_neg = 0; m_disp = k; m_mode = M_A;
            end else if (k >= 10 && k <= 12 && !m_neg) begin
                m_a = m_res; m_op = k; m_b = 0; m_nb = 0; m_disp = 0; m_mode = M_B;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " disp"},   32'(valor_display), 32'(m_disp));
        check({tag, " neg"},    32'(negativo),      32'(m_neg));
        check({tag, " erro"},   32'(erro),          32'(m_err));
        check({tag, " pronto"}, 32'(pronto),        32'(m_pronto));
    endtask

    task automatic cycle(input bit r, input bit v, input int k, input string tag);
        rst = r; dado_valido = v; dado = 4'(k);
        op_codificada = enc(k); eh_igual = (k == 13);
        @(posedge clk);
        model_edge(r, v, k);
        #1;
        check_all(tag);
        rst = 1'b0; dado_valido = 1'b0;
    endtask

    task automatic key(input int k);
        cycle(1'b0, 1'b1, k, $sformatf("key%0d", k));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 15, "idle");
    endtask

    initial begin
        int r_sel, k;
        bit r, v;
        rst = 1'b1; dado_valido = 1'b0; dado = 4'd0; op_codificada = 2'b00; eh_igual = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 0, "reset");
        cycle(1'b1, 1'b0, 0, "reset");
        check("reset disp", 32'(valor_display), 0);
        check("reset flags", 32'({negativo, erro, pronto}), 0);

        // 12 + 34, with result two cycles after the equals strobe
        key(1); key(2);
        check("t1 A", 32'(valor_display), 12);
        key(10); key(3); key(4);
        check("t1 B", 32'(valor_display), 34);
        key(13);
        check("t1 calc pronto", 32'(pronto), 0);
        idle();
        check("t1 sum", 32'(valor_display), 46);
        check("t1 pronto", 32'(pronto), 1);
        check("t1 neg", 32'(negativo), 0);
        idle();
        check("t1 pronto drop", 32'(pronto), 0);

        // 5 - 9, then an operation on a negative result is ignored
        key(14); key(5); key(11); key(9); key(13); idle();
        check("t2 mag", 32'(valor_display), 4);
        check("t2 neg", 32'(negativo), 1);
        key(10);
        check("t2 op ignored", 32'(valor_display), 4);

        // 9999 * 2 overflows
        key(14); key(9); key(9); key(9); key(9); key(12); key(2); key(13); idle();
        check("t3 erro", 32'(erro), 1);
        check("t3 disp", 32'(valor_display), 0);
        check("t3 no pronto", 32'(pronto), 0);
        key(7);
        check("t3 stuck", 32'({erro, valor_display}), 32'({1'b1, 14'd0}));
        key(14);
        check("t3 clear", 32'({valor_display, negativo, erro, pronto}), 0);
        key(5);
        check("t3 back in A", 32'(valor_display), 5);

        // fifth digit dropped, then reset mid-entry
        key(14); key(1); key(2); key(3); key(4); key(5);
        check("t4 4 digits", 32'(valor_display), 1234);
        cycle(1'b1, 1'b1, 6, "rst mid");
        check("t4 rst", 32'({valor_display, negativo, erro, pronto}), 0);

        // chaining and operation replacement
        key(3); key(10); key(4); key(13); idle();
        check("t5 3+4", 32'(valor_display), 7);
        key(10); key(5); key(13); idle();
        check("t5 chain", 32'(valor_display), 12);
        key(14); key(8); key(10); key(11); key(3); key(13); idle();
        check("t5 replaced op", 32'(valor_display), 5);
        check("t5 replaced neg", 32'(negativo), 0);

        // backspace key
        key(14); key(1); key(2); key(3); key(15); key(4);
`ifdef APAGAR_EN
        check("t6 backspace", 32'(valor_display), 124);
`else
        check("t6 backspace", 32'(valor_display), 1234);
`endif

        // random key stream, including keys during evaluation and occasional resets
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            r_sel = $urandom_range(0, 99);
            if (r_sel < 60)      k = $urandom_range(0, 9);
            else if (r_sel < 78) k = $urandom_range(10, 12);
            else if (r_sel < 90) k = 13;
            else if (r_sel < 93) k = 14;
            else                 k = 15;
            cycle(r, v, k, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
